// File: rtl/axi_burst_sched_pkg.sv
// Shared types and constants for the AXI burst scheduler.
// Holds the FSM encoding, burst-type codes and command field widths.
package axi_burst_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WDATA,
      WRESP,
      RDATA
   } state_t;

   localparam logic [1:0] FIXED = 2'd0;
   localparam logic [1:0] INCR  = 2'd1;
   localparam logic [1:0] WRAP  = 2'd2;

   localparam int BLEN_W  = 6;
   localparam int BSIZE_W = 9;

endpackage

// File: rtl/axi_burst_sched_if.sv
// Requester-side and AXI-top-side signals of the burst scheduler.
// The master modport is the scheduler's view; slave is the environment's view.
interface axi_burst_sched_if
   import axi_burst_sched_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int size = 4
);
   localparam int DW = size * 8;

   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_write;
   logic [NREQ*DW-1:0]     req_addr;
   logic [NREQ*BLEN_W-1:0] req_len;
   logic [NREQ*2-1:0]      req_typ;
   logic [NREQ*DW-1:0]     req_wdata;
   logic [NREQ-1:0]        req_wvalid;
   logic [NREQ-1:0]        req_ack;
   logic [NREQ-1:0]        req_wready;
   logic [DW-1:0]          rd_data;
   logic [NREQ-1:0]        rd_valid;
   logic [NREQ-1:0]        done;
   logic [NREQ-1:0]        err;

   logic                   transfer;
   logic [DW-1:0]          wadd;
   logic [DW-1:0]          radd;
   logic [BSIZE_W-1:0]     bsize;
   logic [BLEN_W-1:0]      blen;
   logic [1:0]             btyp;
   logic [DW-1:0]          datain;
   logic                   dlast;
   logic                   wbeat;
   logic                   bdone;
   logic                   rbeat;
   logic                   rlast;
   logic [DW-1:0]          dataout;

   modport master (
      input  req_valid, req_write, req_addr, req_len, req_typ, req_wdata, req_wvalid,
      input  wbeat, bdone, rbeat, rlast, dataout,
      output req_ack, req_wready, rd_data, rd_valid, done, err,
      output transfer, wadd, radd, bsize, blen, btyp, datain, dlast
   );

   modport slave (
      output req_valid, req_write, req_addr, req_len, req_typ, req_wdata, req_wvalid,
      output wbeat, bdone, rbeat, rlast, dataout,
      input  req_ack, req_wready, rd_data, rd_valid, done, err,
      input  transfer, wadd, radd, bsize, blen, btyp, datain, dlast
   );

endinterface

// File: rtl/axi_burst_sched_rr_arbiter.sv
// Round-robin grant: first requesting index after ptr, wrapping modulo NREQ.
module axi_burst_sched_rr_arbiter #(
   parameter int NREQ = 2,
   localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx,
   output logic            gnt_any
);

   int c;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      c       = 0;
      for (int k = 1; k <= NREQ; k++) begin
         c = (int'(ptr) + k) % NREQ;
         if (!gnt_any && req[c]) begin
            gnt[c]  = 1'b1;
            gnt_idx = IW'(c);
            gnt_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_burst_sched.sv
// Shares one AXI datapath between NREQ requesters, one burst in flight at a time.
//   state | meaning
//   IDLE  | arbitrate, ack winner, latch its command
//   ISSUE | one-cycle transfer strobe with start address
//   WDATA | forward write beats of the granted requester
//   WRESP | wait for the write response
//   RDATA | forward read beats until rlast
module axi_burst_sched
   import axi_burst_sched_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int size    = 4,
   parameter int TIMEOUT = 1024
) (
   input logic              aclk,
   input logic              areset,
   axi_burst_sched_if.master bus
);
   localparam int DW  = size * 8;
   localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WDW = $clog2(TIMEOUT);

   state_t              state, state_nx;
   logic [IW-1:0]       ptr, gnt_idx;
   logic [NREQ-1:0]     gnt_oh;
   logic                gnt_any;
   logic                wr_q;
   logic [DW-1:0]       addr_q;
   logic [BLEN_W-1:0]   len_q, cnt;
   logic [1:0]          typ_q;
   logic [WDW-1:0]      wdog;
   logic                wr_hs, rd_hs, abort;

   axi_burst_sched_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req     (bus.req_valid),
      .ptr     (ptr),
      .gnt     (gnt_oh),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   assign wr_hs = (state == WDATA) && bus.wbeat && bus.req_wvalid[ptr];
   assign rd_hs = (state == RDATA) && bus.rbeat;
   // Watchdog is a down-counter loaded at issue; zero outside IDLE means the burst hung.
   assign abort = (state != IDLE) && (wdog == '0);

   always_ff @(posedge aclk) begin
      if (areset) begin
         state  <= IDLE;
         ptr    <= IW'(NREQ - 1);
         cnt    <= '0;
         wdog   <= '0;
         wr_q   <= 1'b0;
         addr_q <= '0;
         len_q  <= '0;
         typ_q  <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && gnt_any) begin
            ptr    <= gnt_idx;
            wr_q   <= bus.req_write[gnt_idx];
            addr_q <= bus.req_addr[int'(gnt_idx)*DW +: DW];
            len_q  <= bus.req_len[int'(gnt_idx)*BLEN_W +: BLEN_W];
            typ_q  <= bus.req_typ[int'(gnt_idx)*2 +: 2];
            cnt    <= '0;
            wdog   <= WDW'(TIMEOUT - 1);
         end else if (state != IDLE) begin
            wdog <= wdog - 1'b1;
            if (wr_hs || rd_hs) cnt <= cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nx       = state;
      bus.req_ack    = '0;
      bus.req_wready = '0;
      bus.rd_data    = '0;
      bus.rd_valid   = '0;
      bus.done       = '0;
      bus.err        = '0;
      bus.transfer   = 1'b0;
      bus.wadd       = '0;
      bus.radd       = '0;
      bus.bsize      = '0;
      bus.blen       = '0;
      bus.btyp       = '0;
      bus.datain     = '0;
      bus.dlast      = 1'b0;
      if (!areset) begin
         if (state != IDLE) begin
            bus.bsize = BSIZE_W'(size);
            bus.blen  = len_q;
            bus.btyp  = typ_q;
         end
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  bus.req_ack = gnt_oh;
                  state_nx    = ISSUE;
               end
            end
            ISSUE: begin
               bus.transfer = 1'b1;
               if (wr_q) bus.wadd = addr_q;
               else      bus.radd = addr_q;
               state_nx = wr_q ? WDATA : RDATA;
            end
            WDATA: begin
               bus.datain          = bus.req_wdata[int'(ptr)*DW +: DW];
               bus.req_wready[ptr] = wr_hs;
               bus.dlast           = (cnt == len_q);
               if (wr_hs && cnt == len_q) state_nx = WRESP;
            end
            WRESP: begin
               if (bus.bdone) begin
                  bus.done[ptr] = 1'b1;
                  state_nx      = IDLE;
               end
            end
            RDATA: begin
               if (rd_hs) begin
                  bus.rd_data       = bus.dataout;
                  bus.rd_valid[ptr] = 1'b1;
                  if (bus.rlast) begin
                     bus.done[ptr] = 1'b1;
                     state_nx      = IDLE;
                  end
               end
            end
            default: state_nx = IDLE;
         endcase
         if (abort) begin
            bus.done     = '0;
            bus.err[ptr] = 1'b1;
            state_nx     = IDLE;
         end
      end
   end

endmodule

// File: tb/tb_axi_burst_sched.sv
// Directed bench for axi_burst_sched: two requesters, 32-bit data, watchdog of 16 cycles.
module tb_axi_burst_sched;
   import axi_burst_sched_pkg::*;

   localparam int NREQ = 2;
   localparam int SZ   = 4;

   logic aclk;
   logic areset;
   int   checks = 0;
   int   errors = 0;

   axi_burst_sched_if #(.NREQ(NREQ), .size(SZ)) bus ();

   axi_burst_sched #(.NREQ(NREQ), .size(SZ), .TIMEOUT(16)) dut (
      .aclk   (aclk),
      .areset (areset),
      .bus    (bus)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic settle();
      @(negedge aclk);
   endtask

   task automatic adv();
      @(posedge aclk);
      #1;
   endtask

   task automatic set_req(input int i, input logic w, input logic [31:0] a,
                          input logic [5:0] l, input logic [1:0] t);
      bus.req_write[i]        = w;
      bus.req_addr[i*32 +: 32] = a;
      bus.req_len[i*6 +: 6]    = l;
      bus.req_typ[i*2 +: 2]    = t;
   endtask

   initial begin
      #200000;
      $display("FAIL tb_timeout act=running exp=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      int n;
      areset         = 1'b1;
      bus.req_valid  = '0;
      bus.req_write  = '0;
      bus.req_addr   = '0;
      bus.req_len    = '0;
      bus.req_typ    = '0;
      bus.req_wdata  = '0;
      bus.req_wvalid = '0;
      bus.wbeat      = 1'b0;
      bus.bdone      = 1'b0;
      bus.rbeat      = 1'b0;
      bus.rlast      = 1'b0;
      bus.dataout    = '0;

      // reset with both requesters pending
      set_req(0, 1'b1, 32'h100, 6'd3, INCR);
      set_req(1, 1'b0, 32'h40, 6'd7, WRAP);
      bus.req_valid = 2'b11;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("rst_outs", 64'({bus.req_ack, bus.done, bus.err, bus.rd_valid, bus.req_wready,
                              bus.transfer, bus.dlast}), 64'd0);
         chk("rst_bsize", 64'(bus.bsize), 64'd0);
         adv();
      end
      areset = 1'b0;

      settle();
      chk("first_ack", 64'(bus.req_ack), 64'd1);
      adv();
      bus.req_valid = 2'b10;

      // write burst of requester 0
      settle();
      chk("wr_transfer", 64'(bus.transfer), 64'd1);
      chk("wr_wadd", 64'(bus.wadd), 64'h100);
      chk("wr_radd", 64'(bus.radd), 64'd0);
      chk("wr_blen", 64'(bus.blen), 64'd3);
      chk("wr_btyp", 64'(bus.btyp), 64'(INCR));
      chk("wr_bsize", 64'(bus.bsize), 64'd4);
      chk("wr_no_ack", 64'(bus.req_ack), 64'd0);
      adv();
      for (int k = 0; k < 4; k++) begin
         bus.req_wdata[31:0] = 32'hA000_0000 + 32'(k);
         bus.req_wvalid      = 2'b01;
         bus.wbeat           = 1'b1;
         settle();
         chk("wr_datain", 64'(bus.datain), 64'(32'hA000_0000 + 32'(k)));
         chk("wr_wready", 64'(bus.req_wready), 64'd1);
         chk("wr_dlast", 64'(bus.dlast), 64'(k == 3));
         adv();
      end
      bus.req_wvalid = '0;
      bus.wbeat      = 1'b0;
      settle();
      chk("wr_wait_resp", 64'(bus.done), 64'd0);
      adv();
      bus.bdone = 1'b1;
      settle();
      chk("wr_done", 64'(bus.done), 64'd1);
      adv();
      bus.bdone = 1'b0;

      // read burst of requester 1
      settle();
      chk("rd_ack", 64'(bus.req_ack), 64'd2);
      adv();
      bus.req_valid = '0;
      settle();
      chk("rd_transfer", 64'(bus.transfer), 64'd1);
      chk("rd_radd", 64'(bus.radd), 64'h40);
      chk("rd_wadd", 64'(bus.wadd), 64'd0);
      chk("rd_blen", 64'(bus.blen), 64'd7);
      chk("rd_btyp", 64'(bus.btyp), 64'(WRAP));
      adv();
      for (int k = 0; k < 8; k++) begin
         if (k == 4) begin
            bus.rbeat = 1'b0;
            bus.bdone = 1'b1;
            settle();
            chk("rd_gap_valid", 64'(bus.rd_valid), 64'd0);
            chk("rd_bdone_ignored", 64'(bus.done), 64'd0);
            adv();
            bus.bdone = 1'b0;
         end
         bus.rbeat   = 1'b1;
         bus.rlast   = (k == 7);
         bus.dataout = 32'h5500_0000 + 32'(k);
         settle();
         chk("rd_valid", 64'(bus.rd_valid), 64'd2);
         chk("rd_data", 64'(bus.rd_data), 64'(32'h5500_0000 + 32'(k)));
         chk("rd_done", 64'(bus.done), (k == 7) ? 64'd2 : 64'd0);
         adv();
      end
      bus.rbeat = 1'b0;
      bus.rlast = 1'b0;

      // both requesters pending: grants alternate 0,1,0,1
      set_req(0, 1'b0, 32'h200, 6'd0, FIXED);
      set_req(1, 1'b0, 32'h300, 6'd0, FIXED);
      bus.req_valid = 2'b11;
      for (int b = 0; b < 4; b++) begin
         settle();
         chk("rr_ack", 64'(bus.req_ack), 64'(1 << (b % 2)));
         adv();
         settle();
         chk("rr_radd", 64'(bus.radd), (b % 2 == 1) ? 64'h300 : 64'h200);
         chk("rr_single_ack", 64'(bus.req_ack), 64'd0);
         adv();
         bus.rbeat   = 1'b1;
         bus.rlast   = 1'b1;
         bus.dataout = 32'(b);
         settle();
         chk("rr_done", 64'(bus.done), 64'(1 << (b % 2)));
         adv();
         bus.rbeat = 1'b0;
         bus.rlast = 1'b0;
      end
      bus.req_valid = '0;

      // write with stalled beats; latency from req_valid to transfer
      set_req(0, 1'b1, 32'h180, 6'd3, INCR);
      settle();
      chk("idle_quiet", 64'({bus.req_ack, bus.transfer}), 64'd0);
      adv();
      bus.req_valid = 2'b01;
      settle();
      chk("lat_ack", 64'(bus.req_ack), 64'd1);
      chk("lat_no_xfer", 64'(bus.transfer), 64'd0);
      adv();
      bus.req_valid = '0;
      settle();
      chk("lat_xfer", 64'(bus.transfer), 64'd1);
      chk("lat_wadd", 64'(bus.wadd), 64'h180);
      adv();
      for (int k = 0; k < 4; k++) begin
         if (k == 2) begin
            for (int s = 0; s < 5; s++) begin
               bus.req_wvalid = '0;
               bus.wbeat      = 1'b1;
               settle();
               chk("stall_hold", 64'({bus.req_wready, bus.dlast}), 64'd0);
               adv();
            end
         end
         bus.req_wdata[31:0] = 32'hB000_0000 + 32'(k);
         bus.req_wvalid      = 2'b01;
         bus.wbeat           = 1'b1;
         settle();
         chk("stall_wready", 64'(bus.req_wready), 64'd1);
         chk("stall_dlast", 64'(bus.dlast), 64'(k == 3));
         adv();
      end
      bus.req_wvalid = '0;
      bus.wbeat      = 1'b0;
      bus.bdone      = 1'b1;
      settle();
      chk("stall_done", 64'(bus.done), 64'd1);
      adv();
      bus.bdone = 1'b0;

      // watchdog: write response never comes
      set_req(0, 1'b1, 32'h1C0, 6'd0, INCR);
      set_req(1, 1'b0, 32'h240, 6'd0, INCR);
      bus.req_valid = 2'b01;
      settle();
      chk("wd_ack0", 64'(bus.req_ack), 64'd1);
      adv();
      bus.req_valid = 2'b10;
      settle();
      chk("wd_xfer", 64'(bus.transfer), 64'd1);
      adv();
      bus.req_wvalid = 2'b01;
      bus.wbeat      = 1'b1;
      settle();
      chk("wd_dlast", 64'(bus.dlast), 64'd1);
      adv();
      bus.req_wvalid = '0;
      bus.wbeat      = 1'b0;
      // n is the cycle offset from the transfer cycle
      n = 2;
      settle();
      while (bus.err == '0 && n < 40) begin
         adv();
         n++;
         settle();
      end
      chk("wd_offset", 64'(n), 64'd15);
      chk("wd_err", 64'(bus.err), 64'd1);
      chk("wd_no_done", 64'(bus.done), 64'd0);
      adv();
      settle();
      chk("wd_next_ack1", 64'(bus.req_ack), 64'd2);
      adv();
      bus.req_valid = '0;
      settle();
      chk("wd_radd1", 64'(bus.radd), 64'h240);
      adv();
      bus.rbeat = 1'b1;
      bus.rlast = 1'b1;
      settle();
      chk("wd_rd_done", 64'(bus.done), 64'd2);
      adv();
      bus.rbeat = 1'b0;
      bus.rlast = 1'b0;
      bus.bdone = 1'b1;
      settle();
      chk("idle_bdone_ignored", 64'(bus.done), 64'd0);
      adv();
      bus.bdone = 1'b0;

      // reset in the middle of a read burst
      set_req(0, 1'b0, 32'h80, 6'd0, INCR);
      bus.req_valid = 2'b01;
      settle();
      chk("mr_ack0", 64'(bus.req_ack), 64'd1);
      adv();
      bus.req_valid = '0;
      adv();
      areset    = 1'b1;
      bus.rbeat = 1'b1;
      bus.rlast = 1'b1;
      settle();
      chk("mr_no_done", 64'({bus.done, bus.err, bus.rd_valid}), 64'd0);
      adv();
      areset        = 1'b0;
      bus.rbeat     = 1'b0;
      bus.rlast     = 1'b0;
      bus.req_valid = 2'b11;
      settle();
      chk("mr_ptr_reset", 64'(bus.req_ack), 64'd1);
      adv();
      bus.req_valid = '0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
